// File: rtl/spw_rx_fifo_port_if.sv
// Bus bundle for spw_rx_fifo_port: Avalon-MM register access, codec character
// stream (valid/ready) and the interrupt line.
interface spw_rx_fifo_port_if #(
  parameter int DATA_W = 9
);
  logic [1:0]        address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              irq;

  modport master (
    output address, read, write, writedata, in_data, in_valid,
    input  readdata, in_ready, irq
  );

  modport slave (
    input  address, read, write, writedata, in_data, in_valid,
    output readdata, in_ready, irq
  );
endinterface

// File: rtl/spw_rx_fifo_port.sv
// SpaceWire receive FIFO port: buffers codec characters in a DEPTH-entry FIFO and
// exposes DATA/STATUS/CONTROL/THRESH over Avalon-MM. Define SPW_RX_IRQ_EN for threshold irq.
module spw_rx_fifo_port #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  spw_rx_fifo_port_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              stall_q, stall_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              ctrl_wr, flush_now, stall_clr;
  logic              empty, full, rdy, push, pop;
  logic              irq_en_rd;
  logic [LVL_W-1:0]  thresh_rd;
  logic              unused_wdata;

  assign unused_wdata = ^bus.writedata;

  always_comb begin
    ctrl_wr   = bus.write && (bus.address == ADDR_CTRL);
    flush_now = ctrl_wr && bus.writedata[0];
    stall_clr = ctrl_wr && bus.writedata[2];
    empty     = (level_q == '0);
    full      = (level_q == LVL_FULL);
    // A flush blocks acceptance so no character lands in a FIFO being emptied.
    rdy       = reset_n && !full && !flush_now;
    push      = bus.in_valid && rdy;
    pop       = bus.read && (bus.address == ADDR_DATA) && !empty && !flush_now;
  end

  assign bus.in_ready = rdy;
  assign bus.readdata = readdata_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_now) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
    // Overflow attempt is sticky; a simultaneous clear loses to a new overflow.
    stall_d = (bus.in_valid && full) || (stall_q && !stall_clr);
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA: begin
        if (!empty) begin
          readdata_d[31]           = 1'b1;
          readdata_d[DATA_W-1:0]   = mem_q[rd_ptr_q];
        end
      end
      ADDR_STATUS: begin
        readdata_d[LVL_W-1:0] = level_q;
        readdata_d[16]        = empty;
        readdata_d[17]        = full;
        readdata_d[18]        = stall_q;
      end
      ADDR_CTRL: readdata_d[1] = irq_en_rd;
      default:   readdata_d[LVL_W-1:0] = thresh_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      stall_q    <= 1'b0;
      readdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      stall_q    <= stall_d;
      readdata_q <= readdata_d;
    end
  end

  // Storage is never reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

`ifdef SPW_RX_IRQ_EN
  localparam logic [LVL_W-1:0] THR_RST = LVL_W'(DEPTH / 2);

  logic             irq_en_q, irq_en_d;
  logic [LVL_W-1:0] thresh_q, thresh_d;
  logic             irq_q, irq_d;

  function automatic logic [LVL_W-1:0] clamp_thresh(input logic [LVL_W-1:0] v);
    if (v == '0)     return LVL_W'(1);
    if (v > LVL_FULL) return LVL_FULL;
    return v;
  endfunction

  always_comb begin
    irq_en_d = ctrl_wr ? bus.writedata[1] : irq_en_q;
    thresh_d = thresh_q;
    if (bus.write && (bus.address == ADDR_THRESH))
      thresh_d = clamp_thresh(bus.writedata[LVL_W-1:0]);
    irq_d = irq_en_q && ((level_d >= thresh_q) || stall_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      thresh_q <= THR_RST;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en_rd = irq_en_q;
  assign thresh_rd = thresh_q;
  assign bus.irq   = irq_q;
`else
  assign irq_en_rd = 1'b0;
  assign thresh_rd = '0;
  assign bus.irq   = 1'b0;
`endif

endmodule

// File: tb/tb_spw_rx_fifo_port.sv
// Testbench for spw_rx_fifo_port: vector table, corner-case sequences and random
// traffic, all checked against a queue-based model of the port.
module tb_spw_rx_fifo_port;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 16;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
`ifdef SPW_RX_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif
  localparam logic [31:0] THR_RD = IRQ_BUILD ? 32'd8 : 32'd0;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  spw_rx_fifo_port_if #(.DATA_W(DATA_W)) bus();

  spw_rx_fifo_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int unsigned fifo_m[$];
  bit          stall_m, irq_en_m, irq_m;
  int unsigned thresh_m;

  typedef struct {
    logic [1:0]        a;
    bit                rd;
    bit                wr;
    logic [31:0]       wd;
    bit                v;
    logic [DATA_W-1:0] d;
    logic [31:0]       exp_rd;
    bit                exp_rdy;
  } vec_t;

  vec_t vecs[20];
  logic r;
  int   acc, pushed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: if (fifo_m.size() != 0) v = 32'h8000_0000 | fifo_m[0];
      2'd1: begin
        v = 32'(fifo_m.size());
        v[16] = (fifo_m.size() == 0);
        v[17] = (fifo_m.size() == DEPTH);
        v[18] = stall_m;
      end
      2'd2: v[1] = irq_en_m;
      default: v = IRQ_BUILD ? 32'(thresh_m) : 32'd0;
    endcase
    return v;
  endfunction

  // One bus cycle: drive, check in_ready, advance model, check registered outputs.
  task automatic cyc(input bit rn, input logic [1:0] a, input bit rd, input bit wr,
                     input logic [31:0] wd, input bit v, input logic [DATA_W-1:0] d,
                     output logic rdy);
    bit flush, exp_rdy, push, pop, old_stall, old_en;
    int unsigned old_thr, tv;
    logic [31:0] exp_rd;
    reset_n = rn; bus.address = a; bus.read = rd; bus.write = wr;
    bus.writedata = wd; bus.in_valid = v; bus.in_data = d;
    #1;
    flush   = wr && (a == 2'd2) && wd[0];
    exp_rdy = rn && (fifo_m.size() != DEPTH) && !flush;
    rdy     = bus.in_ready;
    check("in_ready", {31'b0, rdy}, {31'b0, exp_rdy});
    exp_rd    = rn ? model_rd(a) : 32'h0;
    old_stall = stall_m; old_en = irq_en_m; old_thr = thresh_m;
    if (!rn) begin
      fifo_m.delete(); stall_m = 0; irq_en_m = 0; thresh_m = DEPTH / 2; irq_m = 0;
    end else begin
      push = v && exp_rdy;
      pop  = rd && (a == 2'd0) && (fifo_m.size() != 0) && !flush;
      if (v && fifo_m.size() == DEPTH) stall_m = 1;
      else if (wr && a == 2'd2 && wd[2]) stall_m = 0;
      if (flush) fifo_m.delete();
      else begin
        if (pop)  void'(fifo_m.pop_front());
        if (push) fifo_m.push_back(int'(d));
      end
      if (IRQ_BUILD && wr && a == 2'd2) irq_en_m = wd[1];
      if (IRQ_BUILD && wr && a == 2'd3) begin
        tv = int'(wd[LVL_W-1:0]);
        if (tv == 0) tv = 1;
        if (tv > DEPTH) tv = DEPTH;
        thresh_m = tv;
      end
      irq_m = IRQ_BUILD && old_en && ((fifo_m.size() >= old_thr) || old_stall);
    end
    @(posedge clk); #1;
    check("readdata", bus.readdata, exp_rd);
    check("irq", {31'b0, bus.irq}, {31'b0, irq_m});
  endtask

  task automatic push_c(input logic [DATA_W-1:0] d);
    logic rr;
    cyc(1, 2'd1, 0, 0, 32'h0, 1, d, rr);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    logic rr;
    cyc(1, a, 1, 0, 32'h0, 0, '0, rr);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
    logic rr;
    cyc(1, a, 0, 1, wd, 0, '0, rr);
  endtask

  initial begin
    vecs[0]  = '{2'd1, 1'b0, 1'b0, 32'h0,        1'b1, 9'h1A5, 32'h0001_0000, 1'b1};
    vecs[1]  = '{2'd1, 1'b0, 1'b0, 32'h0,        1'b1, 9'h0FF, 32'h0000_0001, 1'b1};
    vecs[2]  = '{2'd1, 1'b0, 1'b0, 32'h0,        1'b1, 9'h100, 32'h0000_0002, 1'b1};
    vecs[3]  = '{2'd1, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h0000_0003, 1'b1};
    vecs[4]  = '{2'd0, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h8000_01A5, 1'b1};
    vecs[5]  = '{2'd0, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h8000_00FF, 1'b1};
    vecs[6]  = '{2'd0, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h8000_0100, 1'b1};
    vecs[7]  = '{2'd0, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{2'd1, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h0001_0000, 1'b1};
    vecs[9]  = '{2'd2, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h0000_0000, 1'b1};
    vecs[10] = '{2'd3, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, THR_RD,        1'b1};
    vecs[11] = '{2'd0, 1'b0, 1'b1, 32'h0000_FFFF, 1'b0, 9'h000, 32'h0000_0000, 1'b1};
    vecs[12] = '{2'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 9'h055, 32'h0001_0000, 1'b1};
    vecs[13] = '{2'd1, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h0000_0001, 1'b1};
    vecs[14] = '{2'd0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 9'h000, 32'h8000_0055, 1'b1};
    vecs[15] = '{2'd1, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h0001_0000, 1'b1};
    vecs[16] = '{2'd0, 1'b1, 1'b0, 32'h0,        1'b1, 9'h0AA, 32'h0000_0000, 1'b1};
    vecs[17] = '{2'd1, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h0000_0001, 1'b1};
    vecs[18] = '{2'd0, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h8000_00AA, 1'b1};
    vecs[19] = '{2'd1, 1'b1, 1'b0, 32'h0,        1'b0, 9'h000, 32'h0001_0000, 1'b1};

    cyc(0, 2'd0, 0, 0, 32'h0, 0, '0, r);
    cyc(0, 2'd1, 0, 0, 32'h0, 1, 9'h1, r);
    check("reset_readdata", bus.readdata, 32'h0);

    foreach (vecs[i]) begin
      cyc(1, vecs[i].a, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].v, vecs[i].d, r);
      check($sformatf("vec%0d_rd", i), bus.readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_rdy", i), {31'b0, r}, {31'b0, vecs[i].exp_rdy});
    end

    // Fill to full with in_valid held, then stall set-wins and clear
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 2'd1, 0, 0, 32'h0, 1, 9'(i + 32), r);
      if (r) acc++;
    end
    check("fill_accepts", 32'(acc), 32'd16);
    rd_reg(2'd1);
    check("fill_status", bus.readdata, 32'h0006_0010);
    cyc(1, 2'd2, 0, 1, 32'h4, 1, 9'h077, r);
    rd_reg(2'd1);
    check("stall_set_wins", bus.readdata, 32'h0006_0010);
    wr_reg(2'd2, 32'h4);
    rd_reg(2'd1);
    check("stall_cleared", bus.readdata, 32'h0002_0010);
    rd_reg(2'd0);
    check("fill_first_pop", bus.readdata, 32'h8000_0020);
    while (fifo_m.size() != 0) rd_reg(2'd0);

    // Wrap-around: 40 pushes with level kept at most 3
    pushed = 0;
    for (int c = 0; c < 400 && pushed < 40; c++) begin
      bit dp, dr;
      dp = (fifo_m.size() < 3) && ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 1) == 1);
      cyc(1, 2'd0, dr, 0, 32'h0, dp, 9'($urandom), r);
      if (dp && r) pushed++;
    end
    check("wrap_pushes", 32'(pushed), 32'd40);
    while (fifo_m.size() != 0) rd_reg(2'd0);

    // Simultaneous push and pop at level 5
    for (int i = 0; i < 5; i++) push_c(9'(32'h101 + i));
    cyc(1, 2'd0, 1, 0, 32'h0, 1, 9'h106, r);
    check("simul_head", bus.readdata, 32'h8000_0101);
    rd_reg(2'd1);
    check("simul_level", bus.readdata, 32'h0000_0005);
    for (int i = 0; i < 5; i++) begin
      rd_reg(2'd0);
      check($sformatf("simul_pop%0d", i), bus.readdata, 32'h8000_0102 + 32'(i));
    end

    // Flush with a character held by the source
    for (int i = 0; i < 7; i++) push_c(9'(i + 1));
    cyc(1, 2'd2, 0, 1, 32'h1, 1, 9'h1CC, r);
    check("flush_ready", {31'b0, r}, 32'h0);
    cyc(1, 2'd1, 0, 0, 32'h0, 1, 9'h1CC, r);
    check("post_flush_ready", {31'b0, r}, 32'h1);
    check("post_flush_status", bus.readdata, 32'h0001_0000);
    rd_reg(2'd1);
    check("held_accepted", bus.readdata, 32'h0000_0001);
    rd_reg(2'd0);
    check("held_data", bus.readdata, 32'h8000_01CC);

    // Synchronous reset with level 9
    for (int i = 0; i < 9; i++) push_c(9'(i + 64));
    cyc(0, 2'd1, 1, 0, 32'h0, 1, 9'h055, r);
    check("reset_ready", {31'b0, r}, 32'h0);
    check("reset_rd", bus.readdata, 32'h0);
    rd_reg(2'd1);
    check("after_reset_status", bus.readdata, 32'h0001_0000);
    rd_reg(2'd3);
    check("after_reset_thresh", bus.readdata, THR_RD);

`ifdef SPW_RX_IRQ_EN
    wr_reg(2'd3, 32'h4);
    wr_reg(2'd2, 32'h2);
    for (int i = 0; i < 4; i++) begin
      push_c(9'(i + 200));
      check($sformatf("irq_push%0d", i), {31'b0, bus.irq}, (i == 3) ? 32'h1 : 32'h0);
    end
    rd_reg(2'd0);
    check("irq_fall", {31'b0, bus.irq}, 32'h0);
    wr_reg(2'd3, 32'h0);
    rd_reg(2'd3);
    check("thresh_clamp_lo", bus.readdata, 32'h1);
    wr_reg(2'd3, 32'h1F);
    rd_reg(2'd3);
    check("thresh_clamp_hi", bus.readdata, 32'h10);
    wr_reg(2'd2, 32'h5);
`else
    wr_reg(2'd3, 32'h5);
    rd_reg(2'd3);
    check("thresh_ignored", bus.readdata, 32'h0);
    wr_reg(2'd2, 32'h2);
    rd_reg(2'd2);
    check("ctrl_bit1_zero", bus.readdata, 32'h0);
    for (int i = 0; i < 10; i++) push_c(9'(i));
    check("irq_tied", {31'b0, bus.irq}, 32'h0);
    wr_reg(2'd2, 32'h5);
`endif

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [1:0]  a;
      logic [31:0] wd;
      a  = ($urandom_range(0, 1) == 1) ? 2'd0 : 2'($urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) wd[0] = 1'b0;
      cyc(1, a, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, wd,
          $urandom_range(0, 1) == 1, 9'($urandom), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spw_rx_fifo_port.md
Name: spw_rx_fifo_port

Overview:
Parametrised successor to the single-register SpaceWire data input port. Accepts N-bit characters from the SpaceWire codec receive side over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Exposes data, status and control registers to the CPU over an Avalon-MM slave with one-cycle registered read latency. It lets software drain bursts without losing characters.

Parameters:
DATA_W, 9, character width (8 data bits plus control flag), 1..31
DEPTH, 16, FIFO entries, power of 2, >=2
LVL_W, $clog2(DEPTH)+1 (derived localparam, not overridable), occupancy counter width

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk
address  in  2  Avalon word address: 0 DATA, 1 STATUS, 2 CONTROL, 3 THRESH
read  in  1  Avalon read strobe
write  in  1  Avalon write strobe
writedata  in  32  Avalon write data
readdata  out  32  registered read data
in_data  in  DATA_W  character from codec
in_valid  in  1  in_data valid
in_ready  out  1  port can accept a character this cycle
irq  out  1  level interrupt (see Optional Feature)

Behaviour:
- Reset (reset_n=0 at clk edge): pointers=0, level=0, stall flag=0, irq enable=0, THRESH=DEPTH/2, readdata=0. While reset_n=0, in_ready=0.
- in_ready = (level != DEPTH) && !flush_now, where flush_now = write && address==2 && writedata[0]. Combinational.
- Push: in_valid && in_ready -> in_data written at wr_ptr. wr_ptr wraps modulo DEPTH. level+1.
- Pop: read && address==0 && level!=0 -> rd_ptr advances (wrap modulo DEPTH). level-1.
- Push and pop in the same cycle: level unchanged, both pointers advance. When level==0, only the push happens. When level==DEPTH, in_ready=0 so only the pop happens.
- readdata is updated every cycle, value sampled from the current address:
  - DATA: bit31 = (level!=0), bits[DATA_W-1:0] = head entry, other bits 0. Returns all zeros when empty.
  - STATUS: [LVL_W-1:0] level, bit16 empty, bit17 full, bit18 stall flag, other bits 0.
  - CONTROL: bit1 irq enable, other bits 0.
  - THRESH: [LVL_W-1:0] threshold.
  - Data for a read strobed in cycle N is valid in cycle N+1. The pop is committed in cycle N.
- Stall flag: sticky. Set in any cycle where in_valid=1 and level==DEPTH. Cleared by a CONTROL write with writedata[2]=1. If set and clear occur in the same cycle, set wins.
- CONTROL write:
  - bit0 flush: self-clearing. Next cycle pointers=0 and level=0. Overrides a pop in the same cycle. No push occurs that cycle because in_ready=0.
  - bit1: irq enable, stored.
  - bit2: stall clear.
- Writes to DATA and STATUS are ignored. read and write asserted together: both are honoured.
- Head data is valid while level!=0. Storage contents are not reset; only pointers are.

Optional Feature:
SPW_RX_IRQ_EN
- Defined:
  - THRESH is writable: writedata[LVL_W-1:0], stored value clamped to the range 1..DEPTH.
  - irq is registered: irq <= irq_enable && (level_next >= threshold || stall flag set). irq resets to 0.
- Undefined:
  - THRESH reads 0 and writes to it are ignored.
  - CONTROL bit1 reads 0.
  - irq tied to 0.
  - The port is still present.

Test Plan:
- Reset then push 0x1A5, 0x0FF, 0x100 -> STATUS reads level=3, empty=0. Three DATA reads return 0x800001A5, 0x800000FF, 0x80000100. A fourth DATA read returns 0x00000000, and STATUS then reads empty=1, level=0.
- Fill: hold in_valid for 20 cycles, DEPTH=16 -> in_ready drops after 16 accepts. STATUS reads full=1, stall=1, level=16. Write CONTROL=0x4 -> stall=0.
- Wrap-around: 40 pushes interleaved with pops so level stays <=3 -> every popped value matches push order. Pointers wrap at least twice.
- Simultaneous push and pop at level=5 -> level stays 5 and data order is preserved. Push and pop at level=0 -> level=1 and the DATA read returns 0x00000000.
- Flush: level=7, write CONTROL=0x1 while in_valid=1 -> in_ready=0 that cycle. Next cycle level=0. The source's held character is accepted in the following cycle.
- Synchronous reset: with level=9, pulse reset_n low for 1 cycle -> level=0, readdata=0, in_ready=0 during reset. With SPW_RX_IRQ_EN defined: THRESH=4, enable=1, 4 pushes -> irq rises the cycle after the 4th accept and falls after a pop.
